// File: rtl/dpram_arbiter_pkg.sv
// Shared constants and width helpers for the dual-port RAM arbiter.
// The pointer width is never allowed to collapse to zero bits.
package dpram_arbiter_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int ADDR_WIDTH_DEFAULT = 5;
  localparam int NREQ_MAX           = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ptr_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dpram_arbiter_if.sv
// Requester-side bus of the arbiter: flattened per-requester request fields
// plus the grant and the shared, one-hot-qualified read response.
interface dpram_arbiter_if
  import dpram_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int NREQ       = 2
);
  logic [NREQ-1:0]            i_valid;
  logic [NREQ-1:0]            i_we;
  logic [NREQ*ADDR_WIDTH-1:0] i_addr;
  logic [NREQ*XLEN-1:0]       i_wdata;
  logic [NREQ-1:0]            o_ready;
  logic [NREQ-1:0]            o_rvalid;
  logic [XLEN-1:0]            o_rdata;

  modport master (
    output i_valid, i_we, i_addr, i_wdata,
    input  o_ready, o_rvalid, o_rdata
  );

  modport slave (
    input  i_valid, i_we, i_addr, i_wdata,
    output o_ready, o_rvalid, o_rdata
  );
endinterface

// File: rtl/dpram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// searching upward with wrap. The pointer register lives in the caller.
module rr_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[c]) begin
        gnt_o[c] = 1'b1;
        idx_o    = PW'(c);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one dual-port RAM between NREQ requesters with independent
// round-robin write and read arbitration and same-address write forwarding.
module dpram_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int NREQ       = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  dpram_arbiter_if.slave        bus,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_wAddr,
  output logic [XLEN-1:0]       o_ram_dataIn,
  output logic [ADDR_WIDTH-1:0] o_ram_rAddr,
  input  logic [XLEN-1:0]       i_ram_q
);

  localparam int PW = ptr_width(NREQ);

  logic [ADDR_WIDTH-1:0] addr_a  [NREQ];
  logic [XLEN-1:0]       wdata_a [NREQ];

  logic [NREQ-1:0] wr_req, rd_req, wr_gnt, rd_gnt;
  logic [PW-1:0]   wr_idx, rd_idx;
  logic            wr_any, rd_any;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NREQ-1:0] rvalid_q;
  logic            byp_q, byp_d;
  logic [XLEN-1:0] byp_data_q, byp_data_d;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_a[gi]  = bus.i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[gi] = bus.i_wdata[gi*XLEN +: XLEN];
  end

  assign wr_req = bus.i_valid & bus.i_we;
  assign rd_req = bus.i_valid & ~bus.i_we;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_wr_arb (
    .req_i (wr_req),
    .ptr_i (wr_ptr_q),
    .gnt_o (wr_gnt),
    .idx_o (wr_idx),
    .any_o (wr_any)
  );

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rd_arb (
    .req_i (rd_req),
    .ptr_i (rd_ptr_q),
    .gnt_o (rd_gnt),
    .idx_o (rd_idx),
    .any_o (rd_any)
  );

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
  endfunction

  // Grants depend only on request inputs and pointers, never on i_ram_q.
  assign bus.o_ready   = wr_gnt | rd_gnt;
  assign o_ram_we      = wr_any;
  assign o_ram_wAddr   = wr_any ? addr_a[wr_idx]  : '0;
  assign o_ram_dataIn  = wr_any ? wdata_a[wr_idx] : '0;
  assign o_ram_rAddr   = rd_any ? addr_a[rd_idx]  : '0;

  always_comb begin
    wr_ptr_d   = wr_any ? next_ptr(wr_idx) : wr_ptr_q;
    rd_ptr_d   = rd_any ? next_ptr(rd_idx) : rd_ptr_q;
    // The RAM returns old data on a collision, so the write data is kept aside.
    byp_d      = wr_any & rd_any & (o_ram_wAddr == o_ram_rAddr);
    byp_data_d = byp_d ? o_ram_dataIn : byp_data_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rvalid_q   <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rvalid_q   <= rd_gnt;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign bus.o_rvalid = rvalid_q;
  assign bus.o_rdata  = (|rvalid_q) ? (byp_q ? byp_data_q : i_ram_q) : '0;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Table-driven bench for dpram_arbiter with a behavioural RAM, a shadow
// memory and a response scoreboard, plus hand-written reset sequences.
module tb_dpram_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dpram_arbiter_if #(.XLEN(32), .ADDR_WIDTH(5), .NREQ(2)) bus ();

  logic        o_ram_we;
  logic [4:0]  o_ram_wAddr;
  logic [31:0] o_ram_dataIn;
  logic [4:0]  o_ram_rAddr;
  bit   [31:0] ram_q;

  dpram_arbiter #(.XLEN(32), .ADDR_WIDTH(5), .NREQ(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus),
    .o_ram_we     (o_ram_we),
    .o_ram_wAddr  (o_ram_wAddr),
    .o_ram_dataIn (o_ram_dataIn),
    .o_ram_rAddr  (o_ram_rAddr),
    .i_ram_q      (ram_q)
  );

  // Environment RAM: synchronous write, registered read returning old data.
  bit [31:0] ram [32];
  always @(posedge clk) begin
    if (o_ram_we) ram[o_ram_wAddr] <= o_ram_dataIn;
    ram_q <= ram[o_ram_rAddr];
  end

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  rdy;
  } vec_t;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] rd;
  } resp_t;

  bit [31:0] shadow [32];
  resp_t     sb [$];
  vec_t      tbl [$];
  int        n_cmp = 0;
  int        n_bad = 0;

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [1:0] rdy);
    vec_t v;
    v.valid = valid; v.we = we; v.a0 = a0; v.d0 = d0;
    v.a1 = a1; v.d1 = d1; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_valid = v.valid;
    bus.i_we    = v.we;
    bus.i_addr  = {v.a1, v.a0};
    bus.i_wdata = {v.d1, v.d0};
  endtask

  // Entered 1 time unit after a rising edge; leaves 1 time unit after the next.
  task automatic run_vec(input vec_t v, input int n);
    logic [1:0]  wg, rg;
    logic [4:0]  wa, ra;
    logic [31:0] wd, rdv;
    resp_t       e;
    drive(v);
    #3;
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.rv = 2'b00;
      e.rd = 32'h0;
    end
    chk("rvalid", {30'b0, bus.o_rvalid}, {30'b0, e.rv});
    chk("rdata", bus.o_rdata, e.rd);
    wg = v.rdy & v.we & v.valid;
    rg = v.rdy & ~v.we & v.valid;
    wa = wg[1] ? v.a1 : v.a0;
    wd = wg[1] ? v.d1 : v.d0;
    ra = rg[1] ? v.a1 : v.a0;
    chk("ready", {30'b0, bus.o_ready}, {30'b0, v.rdy});
    chk("ram_we", {31'b0, o_ram_we}, {31'b0, |wg});
    chk("ram_wAddr", {27'b0, o_ram_wAddr}, (|wg) ? {27'b0, wa} : 32'h0);
    chk("ram_dataIn", o_ram_dataIn, (|wg) ? wd : 32'h0);
    chk("ram_rAddr", {27'b0, o_ram_rAddr}, (|rg) ? {27'b0, ra} : 32'h0);
    if (|rg) begin
      rdv = ((|wg) && (wa == ra)) ? wd : shadow[ra];
      sb.push_back('{rv: rg, rd: rdv});
    end
    if (|wg) shadow[wa] = wd;
    $display("vec %0d: valid=%b we=%b ready=%b rvalid=%b rdata=%h",
             n, v.valid, v.we, bus.o_ready, bus.o_rvalid, bus.o_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle;
    idle = mk(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);

    tbl.push_back(mk(2'b11, 2'b11, 5'd1, 32'h8badf00d, 5'd2, 32'h00c0ffee, 2'b01));
    tbl.push_back(mk(2'b11, 2'b11, 5'd1, 32'h8badf00d, 5'd2, 32'h00c0ffee, 2'b10));
    tbl.push_back(mk(2'b11, 2'b11, 5'd1, 32'h8badf00d, 5'd2, 32'h00c0ffee, 2'b01));
    tbl.push_back(mk(2'b11, 2'b11, 5'd1, 32'h8badf00d, 5'd2, 32'h00c0ffee, 2'b10));
    tbl.push_back(mk(2'b01, 2'b01, 5'd3, 32'hdeadbeef, 5'd0, 32'h0, 2'b01));
    tbl.push_back(idle);
    tbl.push_back(mk(2'b10, 2'b00, 5'd0, 32'h0, 5'd3, 32'h0, 2'b10));
    tbl.push_back(mk(2'b11, 2'b00, 5'd1, 32'h0, 5'd2, 32'h0, 2'b01));
    tbl.push_back(mk(2'b11, 2'b10, 5'd2, 32'h0, 5'd4, 32'hcafebabe, 2'b11));
    tbl.push_back(mk(2'b11, 2'b01, 5'd5, 32'h11112222, 5'd4, 32'h0, 2'b11));
    tbl.push_back(mk(2'b10, 2'b10, 5'd0, 32'h0, 5'd7, 32'hdeadd00d, 2'b10));
    tbl.push_back(mk(2'b11, 2'b01, 5'd7, 32'hcafed00d, 5'd7, 32'h0, 2'b11));
    tbl.push_back(mk(2'b10, 2'b00, 5'd0, 32'h0, 5'd7, 32'h0, 2'b10));
    tbl.push_back(mk(2'b10, 2'b10, 5'd0, 32'h0, 5'd0, 32'h0000aaaa, 2'b10));
    tbl.push_back(mk(2'b01, 2'b01, 5'd9, 32'h99990009, 5'd0, 32'h0, 2'b01));
    tbl.push_back(mk(2'b11, 2'b00, 5'd0, 32'h0, 5'd9, 32'h0, 2'b01));
    tbl.push_back(mk(2'b11, 2'b00, 5'd0, 32'h0, 5'd9, 32'h0, 2'b10));
    tbl.push_back(mk(2'b11, 2'b00, 5'd0, 32'h0, 5'd9, 32'h0, 2'b01));
    tbl.push_back(mk(2'b11, 2'b00, 5'd0, 32'h0, 5'd9, 32'h0, 2'b10));
    tbl.push_back(idle);
    tbl.push_back(idle);

    rst = 1'b1;
    drive(idle);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_ready", {30'b0, bus.o_ready}, 32'h0);
    chk("reset_ram_we", {31'b0, o_ram_we}, 32'h0);
    chk("reset_rvalid", {30'b0, bus.o_rvalid}, 32'h0);
    chk("reset_rdata", bus.o_rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Leave the write pointer at 1 so a post-reset tie proves it was cleared.
    run_vec(mk(2'b01, 2'b01, 5'd10, 32'h0000000a, 5'd0, 32'h0, 2'b01), 100);

    // Reset asserted between a read grant and its response edge.
    drive(mk(2'b01, 2'b00, 5'd10, 32'h0, 5'd0, 32'h0, 2'b01));
    #3;
    chk("rst_seq_ready", {30'b0, bus.o_ready}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_seq_rvalid", {30'b0, bus.o_rvalid}, 32'h0);
    chk("rst_seq_rdata", bus.o_rdata, 32'h0);
    $display("rst seq: rvalid=%b rdata=%h", bus.o_rvalid, bus.o_rdata);
    sb.delete();
    drive(idle);
    rst = 1'b0;

    run_vec(mk(2'b11, 2'b11, 5'd11, 32'h0000000b, 5'd12, 32'h0000000c, 2'b01), 101);
    run_vec(mk(2'b11, 2'b00, 5'd11, 32'h0, 5'd12, 32'h0, 2'b01), 102);
    run_vec(idle, 103);

    // Async clear of a response that is already on the bus.
    drive(mk(2'b10, 2'b00, 5'd0, 32'h0, 5'd11, 32'h0, 2'b10));
    #3;
    chk("async_ready", {30'b0, bus.o_ready}, 32'h2);
    @(posedge clk);
    #1;
    drive(idle);
    chk("async_pre_rvalid", {30'b0, bus.o_rvalid}, 32'h2);
    chk("async_pre_rdata", bus.o_rdata, 32'h0000000b);
    rst = 1'b1;
    #1;
    chk("async_rvalid", {30'b0, bus.o_rvalid}, 32'h0);
    chk("async_rdata", bus.o_rdata, 32'h0);
    $display("async seq: rvalid=%b rdata=%h", bus.o_rvalid, bus.o_rdata);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
Shares one DualPortRam (one synchronous write port, one synchronous read port) between NREQ requesters, e.g. the core load/store unit and the debug/DMA path.
Writes and reads are arbitrated independently, with a separate round-robin pointer for each.
One write and one read can therefore complete in the same cycle.
Read data returns one cycle after grant, and a same-cycle same-address write is forwarded to the read.

Parameters:
XLEN, 32, data width; must match the attached DualPortRam.
ADDR_WIDTH, 5, RAM address width.
NREQ, 2, number of requesters (2..4).

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst  in  1  reset; asynchronous, active-high.
i_valid  in  NREQ  per-requester request valid.
i_we  in  NREQ  per-requester write (1) or read (0).
i_addr  in  NREQ*ADDR_WIDTH  flattened request addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
i_wdata  in  NREQ*XLEN  flattened write data; requester k occupies bits [k*XLEN +: XLEN].
o_ready  out  NREQ  grant; the request is accepted in any cycle where i_valid[k] & o_ready[k].
o_rvalid  out  NREQ  one-hot read response valid.
o_rdata  out  XLEN  read data, shared by all requesters, qualified by o_rvalid.
o_ram_we  out  1  RAM write enable.
o_ram_wAddr  out  ADDR_WIDTH  RAM write address.
o_ram_dataIn  out  XLEN  RAM write data.
o_ram_rAddr  out  ADDR_WIDTH  RAM read address.
i_ram_q  in  XLEN  RAM read data; valid one cycle after o_ram_rAddr is sampled.

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, o_rvalid=0, bypass flag=0, bypass data=0. With no requests, o_ready, o_ram_we, o_ram_wAddr, o_ram_dataIn and o_ram_rAddr are all 0.
- Write arbitration:
  - Candidates are the requesters with i_valid & i_we.
  - The winner is the first candidate at or after wr_ptr, searching upward with wrap at NREQ.
  - Combinationally, in the same cycle: o_ready[winner]=1, o_ram_we=1, and o_ram_wAddr / o_ram_dataIn are driven from the winner's fields.
  - On grant, wr_ptr <= winner+1 mod NREQ. With no grant, wr_ptr holds.
- Read arbitration: identical structure over requesters with i_valid & ~i_we, using rd_ptr. o_ram_rAddr is driven from the winner's address.
- A requester has at most one request per cycle, so a single requester never receives both a write grant and a read grant in the same cycle.
- Read latency is exactly 1 cycle: o_rvalid[winner] is registered and asserted in the cycle after the grant. Back-to-back read grants give back-to-back responses; no read stalls.
- o_rdata:
  - Equals i_ram_q, except when the bypass flag is set, in which case it equals the registered bypass data.
  - When o_rvalid is all-zero, o_rdata is 0.
- Read-during-write: the RAM returns old data on a same-address collision. If the read grant and write grant in cycle N use equal addresses, the bypass flag and bypass data (the write data) are registered. The response in cycle N+1 therefore carries the new data.
- Requester rules:
  - While valid and not ready, the requester holds addr, we and wdata stable.
  - The requester may drop valid at any time.
  - There is no backpressure on responses.
- Fairness: under continuous contention, each requester is granted at least once every NREQ grants of the same type.
- Reset mid-operation: o_rvalid clears asynchronously, in-flight read responses are discarded, and both pointers return to 0. The first tie after reset goes to requester 0.
- The block adds no combinational path from i_ram_q to o_ready.

Decomposition:
- Shared package/header holds the default XLEN and ADDR_WIDTH constants and a clog2 helper for the pointer width.
- One sub-module, rr_arbiter (parameter N):
  - Inputs: req vector and ptr.
  - Outputs: one-hot gnt, winner index and any-grant flag.
  - Combinational only; the pointer register lives in dpram_arbiter.
  - Instantiated twice: once for writes, once for reads.

Test Plan:
- Single writes, then reads: requester 0 writes 32'hdeadbeef to addr 3; requester 1 reads addr 3 two cycles later -> o_ready[1]=1 the same cycle, o_rvalid=2'b10 and o_rdata=32'hdeadbeef the next cycle.
- Write contention: both requesters write continuously (r0 addr 1 with 32'h8badf00d, r1 addr 2 with 32'h00c0ffee) from reset -> grants alternate r0, r1, r0, ... and the RAM holds both values afterwards.
- Concurrent read and write: r0 writes addr 5 while r1 reads addr 4, which holds 32'hcafebabe -> both o_ready bits are 1 the same cycle, and r1 receives 32'hcafebabe next cycle.
- Collision bypass: addr 7 holds 32'hdeadd00d; r0 writes 32'hcafed00d to addr 7 while r1 reads addr 7 the same cycle -> o_rdata=32'hcafed00d next cycle; a later read of addr 7 also returns 32'hcafed00d.
- Read contention: both requesters read addrs 0 and 9 for 4 cycles -> o_rvalid alternates 01, 10, 01, 10 with the correct data, each response one cycle after its grant.
- Async reset: assert i_rst mid-cycle between a read grant and its response -> o_rvalid=0 immediately with no response delivered; after release, the first write tie goes to r0.
